// File: rtl/icg_cell_if.sv
// Bundle of enable/control inputs and gated-clock/statistics outputs for an icg_cell bank.
interface icg_cell_if #(
    parameter int unsigned NUM_GATES = 1,
    parameter int unsigned CNT_W     = 16
);
    logic [NUM_GATES-1:0]       en;
    logic                       tst_en;
    logic                       cnt_clr;
    logic [NUM_GATES-1:0]       clkg;
    logic [NUM_GATES-1:0]       en_lat;
    logic [NUM_GATES*CNT_W-1:0] gated_cnt;

    modport master (
        output en, tst_en, cnt_clr,
        input  clkg, en_lat, gated_cnt
    );

    modport slave (
        input  en, tst_en, cnt_clr,
        output clkg, en_lat, gated_cnt
    );
endinterface

// File: rtl/icg_cell.sv
// Bank of latch-based clock gates with test bypass, reset force-on, optional
// post-enable hold and saturating per-channel gated-edge counters.
module icg_cell #(
    parameter int unsigned NUM_GATES   = 1,
    parameter int unsigned HOLD_CYCLES = 0,
    parameter int unsigned CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst,
    icg_cell_if.slave   bus
);

    localparam int unsigned HOLD_W = 8;

    logic [NUM_GATES-1:0] hold_act;
    logic [NUM_GATES-1:0] en_eff;
    logic [NUM_GATES-1:0] en_lat;

    logic [CNT_W-1:0] cnt_q [NUM_GATES];
    logic [CNT_W-1:0] cnt_d [NUM_GATES];

    // Hold keeps a gate open for HOLD_CYCLES edges after its enable falls
    if (HOLD_CYCLES > 0) begin : g_hold
        logic [HOLD_W-1:0] hold_cnt_q [NUM_GATES];
        logic [HOLD_W-1:0] hold_cnt_d [NUM_GATES];

        always_comb begin
            for (int unsigned i = 0; i < NUM_GATES; i++) begin
                hold_cnt_d[i] = hold_cnt_q[i];
                hold_act[i]   = (hold_cnt_q[i] != '0);
                if (bus.en[i]) begin
                    hold_cnt_d[i] = HOLD_W'(HOLD_CYCLES);
                end else if (hold_cnt_q[i] != '0) begin
                    hold_cnt_d[i] = hold_cnt_q[i] - HOLD_W'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            for (int unsigned i = 0; i < NUM_GATES; i++) begin
                if (rst) begin
                    hold_cnt_q[i] <= '0;
                end else begin
                    hold_cnt_q[i] <= hold_cnt_d[i];
                end
            end
        end
    end else begin : g_no_hold
        assign hold_act = '0;
    end

    assign en_eff = bus.en | {NUM_GATES{bus.tst_en | rst}} | hold_act;

    // Transparent in the low phase so the high pulse can never be cut short
    always_latch begin
        if (!clk) begin
            en_lat <= en_eff;
        end
    end

    assign bus.en_lat = en_lat;
    assign bus.clkg   = {NUM_GATES{clk}} & en_lat;

    // Count edges where the gate was closed; clear wins over increment
    always_comb begin
        for (int unsigned i = 0; i < NUM_GATES; i++) begin
            cnt_d[i] = cnt_q[i];
            if (bus.cnt_clr) begin
                cnt_d[i] = '0;
            end else if (!en_lat[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_GATES; i++) begin
            if (rst) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_GATES; g++) begin : g_cnt_out
        assign bus.gated_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end

endmodule

// File: tb/tb_icg_cell.sv
// Directed bench for icg_cell: three banks (2-gate plain, 1-gate with hold, 1-gate 4-bit counter).
module tb_icg_cell;

    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    int pa0 = 0;
    int pa1 = 0;
    int pb0 = 0;
    int pc0 = 0;
    int s0;
    int s1;

    icg_cell_if #(.NUM_GATES(2), .CNT_W(16)) a_if ();
    icg_cell_if #(.NUM_GATES(1), .CNT_W(16)) b_if ();
    icg_cell_if #(.NUM_GATES(1), .CNT_W(4))  c_if ();

    icg_cell #(.NUM_GATES(2), .HOLD_CYCLES(0), .CNT_W(16)) u_a (.clk(clk), .rst(rst), .bus(a_if));
    icg_cell #(.NUM_GATES(1), .HOLD_CYCLES(3), .CNT_W(16)) u_b (.clk(clk), .rst(rst), .bus(b_if));
    icg_cell #(.NUM_GATES(1), .HOLD_CYCLES(0), .CNT_W(4))  u_c (.clk(clk), .rst(rst), .bus(c_if));

    always #5 clk = ~clk;

    // Every rising edge of a gated clock, including any glitch, is counted
    always @(posedge a_if.clkg[0]) pa0 <= pa0 + 1;
    always @(posedge a_if.clkg[1]) pa1 <= pa1 + 1;
    always @(posedge b_if.clkg[0]) pb0 <= pb0 + 1;
    always @(posedge c_if.clkg[0]) pc0 <= pc0 + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a_if.en = '0; a_if.tst_en = 1'b0; a_if.cnt_clr = 1'b0;
        b_if.en = '0; b_if.tst_en = 1'b0; b_if.cnt_clr = 1'b0;
        c_if.en = '0; c_if.tst_en = 1'b0; c_if.cnt_clr = 1'b0;

        // reset forces gates open
        repeat (3) tick();
        check("rst_pulse_a0", 32'(pa0), 32'd3);
        check("rst_pulse_a1", 32'(pa1), 32'd3);
        check("rst_pulse_b0", 32'(pb0), 32'd3);
        check("rst_pulse_c0", 32'(pc0), 32'd3);
        check("rst_cnt_a",    32'(a_if.gated_cnt), 32'd0);
        check("rst_cnt_b",    32'(b_if.gated_cnt), 32'd0);
        check("rst_cnt_c",    32'(c_if.gated_cnt), 32'd0);
        check("rst_enlat_a",  32'(a_if.en_lat), 32'd3);

        // channel 0 enabled 4 cycles, then both closed 5 cycles
        rst = 1'b0;
        a_if.en = 2'b01;
        s0 = pa0; s1 = pa1;
        repeat (4) tick();
        a_if.en = 2'b00;
        repeat (5) tick();
        check("en_pulse_a0", 32'(pa0 - s0), 32'd4);
        check("en_pulse_a1", 32'(pa1 - s1), 32'd0);
        check("en_cnt_a0",   32'(a_if.gated_cnt[15:0]), 32'd5);
        check("en_cnt_a1",   32'(a_if.gated_cnt[31:16]), 32'd9);
        check("en_cnt_c",    32'(c_if.gated_cnt), 32'd9);
        check("en_enlat_a",  32'(a_if.en_lat), 32'd0);

        // enable pulse inside the high phase must not reach the gate
        s0 = pa0;
        #1 a_if.en[0] = 1'b1;
        #1 a_if.en[0] = 1'b0;
        check("glitch_enlat", 32'(a_if.en_lat[0]), 32'd0);
        tick();
        check("glitch_nopulse", 32'(pa0 - s0), 32'd0);
        @(negedge clk);
        #1 a_if.en[0] = 1'b1;
        @(posedge clk);
        #1;
        check("low_en_pulse", 32'(pa0 - s0), 32'd1);
        check("low_en_enlat", 32'(a_if.en_lat[0]), 32'd1);
        a_if.en[0] = 1'b0;
        check("glitch_cnt_a0", 32'(a_if.gated_cnt[15:0]), 32'd6);
        check("glitch_cnt_a1", 32'(a_if.gated_cnt[31:16]), 32'd11);

        // 4-bit counter saturates at 15
        repeat (4) tick();
        check("sat_cnt_c", 32'(c_if.gated_cnt), 32'd15);
        repeat (5) tick();
        check("sat_hold_c", 32'(c_if.gated_cnt), 32'd15);
        check("sat_pulse_c", 32'(pc0), 32'd3);

        // one-cycle enable with HOLD_CYCLES=3 gives 4 pulses
        s0 = pb0;
        b_if.en = 1'b1;
        tick();
        b_if.en = 1'b0;
        repeat (3) tick();
        check("hold_pulse", 32'(pb0 - s0), 32'd4);
        repeat (3) tick();
        check("hold_stop", 32'(pb0 - s0), 32'd4);
        check("hold_cnt_b", 32'(b_if.gated_cnt), 32'd23);

        // reset during hold ends the hold
        b_if.en = 1'b1;
        tick();
        b_if.en = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        s0 = pb0;
        check("hold_rst_cnt", 32'(b_if.gated_cnt), 32'd0);
        repeat (3) tick();
        check("hold_rst_pulse", 32'(pb0 - s0), 32'd0);
        check("hold_rst_cnt3", 32'(b_if.gated_cnt), 32'd3);
        check("post_rst_cnt_c", 32'(c_if.gated_cnt), 32'd3);

        // test enable opens gates and freezes counters
        s0 = pa0; s1 = pa1;
        a_if.tst_en = 1'b1;
        repeat (10) tick();
        check("tst_pulse_a0", 32'(pa0 - s0), 32'd10);
        check("tst_pulse_a1", 32'(pa1 - s1), 32'd10);
        check("tst_cnt_a0",   32'(a_if.gated_cnt[15:0]), 32'd3);
        check("tst_cnt_a1",   32'(a_if.gated_cnt[31:16]), 32'd3);
        check("tst_enlat_a",  32'(a_if.en_lat), 32'd3);

        // clear wins over a gated edge in the same cycle
        a_if.tst_en = 1'b0;
        a_if.cnt_clr = 1'b1;
        tick();
        check("clr_cnt_a", 32'(a_if.gated_cnt), 32'd0);
        a_if.cnt_clr = 1'b0;
        tick();
        check("clr_inc_a0", 32'(a_if.gated_cnt[15:0]), 32'd1);
        check("clr_inc_a1", 32'(a_if.gated_cnt[31:16]), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
